// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin arbiter.
//   arb_state_e : arbiter FSM state (idle / a grant is outstanding)
//   onehot()    : index -> one-hot vector, ARB_MAX_REQ bits wide; callers
//                 keep the low NUM_REQ bits.
package arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  localparam int unsigned ARB_MAX_REQ = 64;
  localparam int unsigned ARB_IDX_W   = 6;

  function automatic logic [ARB_MAX_REQ-1:0] onehot(input logic [ARB_IDX_W-1:0] idx);
    logic [ARB_MAX_REQ-1:0] one;
    one = {{(ARB_MAX_REQ-1){1'b0}}, 1'b1};
    return one << idx;
  endfunction

endpackage

// File: rtl/priority_encoder.sv
// Priority encoder: the highest set bit wins.
//   req_vec : input request vector
//   idx     : index of the highest set bit (0 when none)
//   valid   : high when any bit of req_vec is set
module priority_encoder #(
  parameter int W     = 8,
  parameter int IDX_W = $clog2(W)
) (
  input  logic [W-1:0]     req_vec,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  always_comb begin
    idx   = '0;
    valid = |req_vec;
    // Ascending scan: the last hit is the highest index.
    for (int i = 0; i < W; i++) begin
      if (req_vec[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter sharing one resource between NUM_REQ requesters.
//   clk       : clock, rising edge
//   rst       : asynchronous active-high reset
//   req       : level request vector
//   gnt       : registered one-hot grant
//   gnt_valid : high when gnt is nonzero
//   gnt_idx   : index of the current owner, 0 when no grant
//
// Handshake: requester i raises req[i] and holds it high for the whole
// transaction; it owns the resource for every cycle gnt[i] is high and ends
// the transaction by dropping req[i]. While others are waiting, an owner is
// preempted after MAX_HOLD consecutive grant cycles (MAX_HOLD=0 disables it).
module rr_arbiter import arb_pkg::*; #(
  parameter int NUM_REQ  = 8,
  parameter int IDX_W    = $clog2(NUM_REQ),
  parameter int MAX_HOLD = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic               gnt_valid,
  output logic [IDX_W-1:0]   gnt_idx
);

  localparam int                 HOLD_W     = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0]  HOLD_MAX   = HOLD_W'(MAX_HOLD);
  localparam logic [HOLD_W-1:0]  HOLD_ONE   = HOLD_W'(1);
  localparam logic [NUM_REQ-1:0] REQ_ONE    = NUM_REQ'(1);
  localparam bit                 PREEMPT_EN = (MAX_HOLD != 0);

  arb_state_e         state, state_n;
  logic [IDX_W-1:0]   last_idx, last_n;
  logic [HOLD_W-1:0]  hold_cnt, hold_n;
  logic [NUM_REQ-1:0] gnt_n;
  logic               valid_n;
  logic [IDX_W-1:0]   idx_n;

  logic               owner_req;
  logic [NUM_REQ-1:0] waiting;
  logic [NUM_REQ-1:0] sel_req;
  logic [NUM_REQ-1:0] lower_mask;
  logic [NUM_REQ-1:0] masked;
  logic [IDX_W-1:0]   m_idx, f_idx, win_idx;
  logic               m_valid, f_valid;
  logic [NUM_REQ-1:0] win_oh;
  logic [ARB_MAX_REQ-1:0] lower_oh_wide, win_oh_wide;
  logic               unused_oh;
  logic               grant_win, go_idle;

  assign owner_req = req[gnt_idx];
  assign waiting   = req & ~gnt;

  // A preemption must skip the current owner, so selection then runs on the
  // waiting set; every other grant decision uses the raw request vector.
  assign sel_req = (state == ARB_BUSY && owner_req) ? waiting : req;

  // Bits strictly below last_idx: searching these first makes priority rotate
  // downward from the previous winner.
  assign lower_oh_wide = onehot(ARB_IDX_W'(last_idx));
  assign lower_mask    = lower_oh_wide[NUM_REQ-1:0] - REQ_ONE;
  assign masked        = sel_req & lower_mask;

  priority_encoder #(.W(NUM_REQ), .IDX_W(IDX_W)) u_pe_masked (
    .req_vec (masked),
    .idx     (m_idx),
    .valid   (m_valid)
  );

  priority_encoder #(.W(NUM_REQ), .IDX_W(IDX_W)) u_pe_full (
    .req_vec (sel_req),
    .idx     (f_idx),
    .valid   (f_valid)
  );

  assign win_idx     = m_valid ? m_idx : f_idx;
  assign win_oh_wide = onehot(ARB_IDX_W'(win_idx));
  assign win_oh      = win_oh_wide[NUM_REQ-1:0];
  assign unused_oh   = ^{lower_oh_wide, win_oh_wide};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ARB_IDLE;
      gnt       <= '0;
      gnt_valid <= 1'b0;
      gnt_idx   <= '0;
      last_idx  <= '0;
      hold_cnt  <= '0;
    end else begin
      state     <= state_n;
      gnt       <= gnt_n;
      gnt_valid <= valid_n;
      gnt_idx   <= idx_n;
      last_idx  <= last_n;
      hold_cnt  <= hold_n;
    end
  end

  always_comb begin
    state_n   = state;
    gnt_n     = gnt;
    valid_n   = gnt_valid;
    idx_n     = gnt_idx;
    last_n    = last_idx;
    hold_n    = hold_cnt;
    grant_win = 1'b0;
    go_idle   = 1'b0;

    case (state)
      ARB_IDLE: begin
        if (f_valid) grant_win = 1'b1;
      end
      ARB_BUSY: begin
        if (!owner_req) begin
          // Release: hand over on the same edge when anyone else is asking.
          if (f_valid) grant_win = 1'b1;
          else         go_idle   = 1'b1;
        end else if (!PREEMPT_EN || hold_cnt < HOLD_MAX || !(|waiting)) begin
          if (hold_cnt < HOLD_MAX) hold_n = hold_cnt + HOLD_ONE;
        end else begin
          grant_win = 1'b1;
        end
      end
      default: state_n = ARB_IDLE;
    endcase

    if (grant_win) begin
      state_n = ARB_BUSY;
      gnt_n   = win_oh;
      valid_n = 1'b1;
      idx_n   = win_idx;
      last_n  = win_idx;
      hold_n  = HOLD_ONE;
    end
    if (go_idle) begin
      state_n = ARB_IDLE;
      gnt_n   = '0;
      valid_n = 1'b0;
      idx_n   = '0;
    end
  end

endmodule

// File: tb/tb_rr_arbiter.sv
module tb_rr_arbiter;

  localparam int N     = 8;
  localparam int MH    = 4;
  localparam int BOUND = (N - 1) * MH + N;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] req = '0;
  logic [N-1:0] gnt;
  logic         gnt_valid;
  logic [2:0]   gnt_idx;
  logic [N-1:0] req0 = '0;
  logic [N-1:0] gnt0;
  logic         gnt_valid0;
  logic [2:0]   gnt_idx0;

  int errors = 0;
  int checks = 0;

  rr_arbiter #(.NUM_REQ(N), .MAX_HOLD(MH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  rr_arbiter #(.NUM_REQ(N), .MAX_HOLD(0)) dut_nopre (
    .clk       (clk),
    .rst       (rst),
    .req       (req0),
    .gnt       (gnt0),
    .gnt_valid (gnt_valid0),
    .gnt_idx   (gnt_idx0)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_out(input string name, input logic [N-1:0] eg, input logic [2:0] ei, input logic ev);
    check({name, "_gnt"}, 32'(gnt), 32'(eg));
    check({name, "_idx"}, 32'(gnt_idx), 32'(ei));
    check({name, "_valid"}, 32'(gnt_valid), 32'(ev));
  endtask

  // behavioural reference model: rotating priority search from last winner
  int m_owner, m_last, m_hold;
  int wait_cnt[N];
  int max_wait;
  logic [N-1:0] exp_q[$];

  function automatic int model_win(input logic [N-1:0] v, input int last);
    for (int i = last - 1; i >= 0; i--) if (v[i]) return i;
    for (int i = N - 1; i >= 0; i--) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_last  = 0;
    m_hold  = 0;
    max_wait = 0;
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
  endtask

  task automatic model_step(input logic [N-1:0] r);
    logic [N-1:0] others;
    if (m_owner < 0 || !r[m_owner]) begin
      if (r != 0) begin
        m_owner = model_win(r, m_last);
        m_last  = m_owner;
        m_hold  = 1;
      end else begin
        m_owner = -1;
      end
    end else begin
      others = r;
      others[m_owner] = 1'b0;
      if (m_hold < MH || others == 0) begin
        if (m_hold < MH) m_hold++;
      end else begin
        m_owner = model_win(others, m_last);
        m_last  = m_owner;
        m_hold  = 1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (r[i] && m_owner != i) wait_cnt[i]++;
      else                      wait_cnt[i] = 0;
      if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
    end
    exp_q.push_back((m_owner < 0) ? '0 : (N'(1) << m_owner));
  endtask

  typedef struct {
    logic [N-1:0] req;
    logic [N-1:0] gnt;
    logic [2:0]   idx;
    logic         valid;
  } vec_t;

  vec_t vecs[$];
  int   hold_left[N];

  initial begin
    logic [N-1:0] nr;
    logic [N-1:0] eg;

    // test 1: async reset with no clock edge, then idle
    #2 rst = 1'b1;
    #1 check_out("reset_async", 8'h00, 3'd0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      check_out("idle", 8'h00, 3'd0, 1'b0);
    end

    // tests 2 and 3: release hand-over and full rotation
    vecs = '{
      '{8'h81, 8'h80, 3'd7, 1'b1},
      '{8'h01, 8'h01, 3'd0, 1'b1},
      '{8'h00, 8'h00, 3'd0, 1'b0},
      '{8'hFF, 8'h80, 3'd7, 1'b1},
      '{8'h7F, 8'h40, 3'd6, 1'b1},
      '{8'hBF, 8'h20, 3'd5, 1'b1},
      '{8'hDF, 8'h10, 3'd4, 1'b1},
      '{8'hEF, 8'h08, 3'd3, 1'b1},
      '{8'hF7, 8'h04, 3'd2, 1'b1},
      '{8'hFB, 8'h02, 3'd1, 1'b1},
      '{8'hFD, 8'h01, 3'd0, 1'b1},
      '{8'hFE, 8'h80, 3'd7, 1'b1},
      '{8'h00, 8'h00, 3'd0, 1'b0}
    };
    foreach (vecs[k]) begin
      req = vecs[k].req;
      tick();
      check_out($sformatf("vec%0d", k), vecs[k].gnt, vecs[k].idx, vecs[k].valid);
    end

    // test 4: preemption after MAX_HOLD cycles; MAX_HOLD=0 never preempts
    req  = 8'h08;
    req0 = 8'h08;
    tick();
    check_out("hold_c1", 8'h08, 3'd3, 1'b1);
    check("nopre_c1", 32'(gnt0), 32'h08);
    req  = 8'h0A;
    req0 = 8'h0A;
    for (int c = 2; c <= 4; c++) begin
      tick();
      check_out($sformatf("hold_c%0d", c), 8'h08, 3'd3, 1'b1);
    end
    tick();
    check_out("preempt", 8'h02, 3'd1, 1'b1);
    check("nopre_c5", 32'(gnt0), 32'h08);
    req = 8'h00;
    for (int c = 0; c < 10; c++) begin
      tick();
      check($sformatf("nopre_hold%0d", c), 32'(gnt0), 32'h08);
    end
    check_out("preempt_idle", 8'h00, 3'd0, 1'b0);
    req0 = 8'h00;
    req  = 8'h08;
    for (int c = 0; c < 20; c++) begin
      tick();
      check_out($sformatf("solo%0d", c), 8'h08, 3'd3, 1'b1);
    end
    check("hold_sat", 32'(dut.hold_cnt), 32'd4);
    req = 8'h00;
    tick();
    check_out("solo_idle", 8'h00, 3'd0, 1'b0);

    // test 5: reset mid-grant clears outputs without an edge and restarts rotation
    req = 8'h20;
    tick();
    check_out("own5", 8'h20, 3'd5, 1'b1);
    #3 rst = 1'b1;
    #1 check_out("mid_reset", 8'h00, 3'd0, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    req = 8'h24;
    tick();
    check_out("post_reset", 8'h20, 3'd5, 1'b1);
    req = 8'h00;
    tick();

    // test 6: random traffic against the model
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < N; i++) hold_left[i] = 0;
    for (int c = 0; c < 2000; c++) begin
      nr = req;
      for (int i = 0; i < N; i++) begin
        if (req[i]) begin
          if (m_owner == i) begin
            if (hold_left[i] == 0) nr[i] = 1'b0;
            else                   hold_left[i]--;
          end
        end else if ($urandom_range(0, 3) == 0) begin
          nr[i] = 1'b1;
          hold_left[i] = $urandom_range(0, 9);
        end
      end
      req = nr;
      tick();
      model_step(req);
      eg = exp_q.pop_front();
      check("rand_gnt", 32'(gnt), 32'(eg));
      check("rand_valid", 32'(gnt_valid), 32'(eg != 0));
      check("rand_idx", 32'(gnt_idx), 32'((m_owner < 0) ? 0 : m_owner));
      check("rand_onehot", 32'($onehot0(gnt)), 32'd1);
      check("rand_req_only", 32'(gnt & ~req), 32'd0);
    end
    check("starvation", 32'(max_wait > BOUND), 32'd0);

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
